// File: rtl/request_scheduler.sv
// -----------------------------------------------------------------------------
// request_scheduler
//
// Upstream stage of the elevator movement controller. Cabin (interior) and hall
// (exterior) button presses are latched into a pending-floor bitmap. A SCAN
// (keep-direction) policy, evaluated against the floor reported back by the
// movement stage, selects one target floor and a direction. A pending bit is
// cleared when the movement stage signals arrival at that floor.
//
// Optional feature: define HOME_RETURN_EN to build an idle counter that parks
// the cabin at HOME_FLOOR after HOME_TIMEOUT idle cycles. Without the macro no
// counter exists and the cabin stays at its last floor indefinitely.
//
// Parameters
//   NUM_FLOORS    number of floors served (2..8)
//   FLOOR_W       floor index width
//   HOME_FLOOR    parking floor for the home-return feature
//   HOME_TIMEOUT  idle cycles before home return (HOME_RETURN_EN only)
//
// Ports
//   CLK             in   system clock, rising edge
//   RST             in   synchronous reset, active-high
//   interior_panel  in   floor index of a cabin button press
//   interior_valid  in   1-cycle strobe qualifying interior_panel
//   exterior_panel  in   floor index of a hall button press
//   exterior_valid  in   1-cycle strobe qualifying exterior_panel
//   current_floor   in   floor the cabin is at / passing
//   arrived         in   1-cycle pulse: cabin stopped at current_floor
//   target_floor    out  floor the movement stage must go to
//   target_valid    out  a request is pending
//   direction       out  00 idle, 01 up, 10 down
//   pending         out  registered request bitmap, bit i = floor i
// -----------------------------------------------------------------------------
module request_scheduler #(
    parameter int NUM_FLOORS   = 8,
    parameter int FLOOR_W      = 3,
    parameter int HOME_FLOOR   = 0,
    parameter int HOME_TIMEOUT = 1000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [FLOOR_W-1:0]    interior_panel,
    input  logic                  interior_valid,
    input  logic [FLOOR_W-1:0]    exterior_panel,
    input  logic                  exterior_valid,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  arrived,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic [1:0]            direction,
    output logic [NUM_FLOORS-1:0] pending
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10
    } state_t;

    // Lowest set bit of a floor mask (0 when the mask is empty).
    function automatic logic [FLOOR_W-1:0] lowest_floor(input logic [NUM_FLOORS-1:0] m);
        lowest_floor = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (m[i]) lowest_floor = FLOOR_W'(i);
        end
    endfunction

    // Highest set bit of a floor mask (0 when the mask is empty).
    function automatic logic [FLOOR_W-1:0] highest_floor(input logic [NUM_FLOORS-1:0] m);
        highest_floor = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (m[i]) highest_floor = FLOOR_W'(i);
        end
    endfunction

    state_t                  state_q;
    logic [FLOOR_W-1:0]      target_q;
    logic                    valid_q;
    logic [1:0]              dir_q;
    logic [NUM_FLOORS-1:0]   pending_q;
    logic [NUM_FLOORS-1:0]   pending_d;

    logic [NUM_FLOORS-1:0]   set_vec;
    logic [NUM_FLOORS-1:0]   clr_vec;
    logic [NUM_FLOORS-1:0]   up_mask;
    logic [NUM_FLOORS-1:0]   dn_mask;
    logic                    up_any;
    logic                    dn_any;
    logic [FLOOR_W-1:0]      up_tgt;
    logic [FLOOR_W-1:0]      dn_tgt;
    logic                    home_set;

`ifdef HOME_RETURN_EN
    localparam int CNT_W = (HOME_TIMEOUT > 1) ? $clog2(HOME_TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] idle_cnt_q;
    logic [CNT_W-1:0] idle_cnt_d;
    logic             idle_cond;

    // The counter only runs while the cabin is parked away from home with
    // nothing to do; any activity (or leaving that situation) restarts it.
    always_comb begin
        idle_cond  = (state_q == ST_IDLE) && (pending_q == '0) &&
                     (current_floor != FLOOR_W'(HOME_FLOOR)) &&
                     !(interior_valid || exterior_valid || arrived);
        home_set   = idle_cond && (idle_cnt_q == CNT_W'(HOME_TIMEOUT - 1));
        idle_cnt_d = '0;
        if (idle_cond && !home_set) idle_cnt_d = idle_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) idle_cnt_q <= '0;
        else     idle_cnt_q <= idle_cnt_d;
    end
`else
    assign home_set = 1'b0;
`endif

    // Request capture and clear. Indices at or above NUM_FLOORS never match the
    // loop and are therefore dropped. The clear is applied last so a press for
    // the floor being arrived at counts as already served.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (interior_valid && (interior_panel == FLOOR_W'(i))) set_vec[i] = 1'b1;
            if (exterior_valid && (exterior_panel == FLOOR_W'(i))) set_vec[i] = 1'b1;
            if (arrived && (current_floor == FLOOR_W'(i)))         clr_vec[i] = 1'b1;
        end
        if (home_set) set_vec[HOME_FLOOR] = 1'b1;
        pending_d = (pending_q | set_vec) & ~clr_vec;
    end

    always_ff @(posedge CLK) begin
        if (RST) pending_q <= '0;
        else     pending_q <= pending_d;
    end

    // Split the registered bitmap around the current floor. The current floor
    // itself belongs to both halves so a request there is served in either
    // sweep direction.
    always_comb begin
        up_mask = '0;
        dn_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            up_mask[i] = pending_q[i] && (FLOOR_W'(i) >= current_floor);
            dn_mask[i] = pending_q[i] && (FLOOR_W'(i) <= current_floor);
        end
        up_any = |up_mask;
        dn_any = |dn_mask;
        up_tgt = lowest_floor(up_mask);
        dn_tgt = highest_floor(dn_mask);
    end

    // SCAN policy: keep the current direction while requests remain ahead,
    // otherwise reverse, otherwise go idle. Outputs are registered alongside
    // the state, so they follow the bitmap with one cycle of latency.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            valid_q  <= 1'b0;
            dir_q    <= 2'b00;
        end else begin
            valid_q <= (pending_q != '0);
            unique case (state_q)
                ST_IDLE, ST_UP: begin
                    if (up_any) begin
                        state_q  <= ST_UP;
                        target_q <= up_tgt;
                        dir_q    <= 2'b01;
                    end else if (dn_any) begin
                        state_q  <= ST_DOWN;
                        target_q <= dn_tgt;
                        dir_q    <= 2'b10;
                    end else begin
                        state_q  <= ST_IDLE;
                        dir_q    <= 2'b00;
                    end
                end
                ST_DOWN: begin
                    if (dn_any) begin
                        state_q  <= ST_DOWN;
                        target_q <= dn_tgt;
                        dir_q    <= 2'b10;
                    end else if (up_any) begin
                        state_q  <= ST_UP;
                        target_q <= up_tgt;
                        dir_q    <= 2'b01;
                    end else begin
                        state_q  <= ST_IDLE;
                        dir_q    <= 2'b00;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    dir_q   <= 2'b00;
                end
            endcase
        end
    end

    assign target_floor = target_q;
    assign target_valid = valid_q;
    assign direction    = dir_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_request_scheduler.sv
module tb_request_scheduler;

    localparam int NUM_FLOORS   = 8;
    localparam int FLOOR_W      = 4;
    localparam int HOME_FLOOR   = 0;
    localparam int HOME_TIMEOUT = 16;

    logic                  CLK;
    logic                  RST;
    logic [FLOOR_W-1:0]    ip, ep, cf;
    logic                  iv, ev, arr;
    logic [FLOOR_W-1:0]    target_floor;
    logic                  target_valid;
    logic [1:0]            direction;
    logic [NUM_FLOORS-1:0] pending;

    request_scheduler #(
        .NUM_FLOORS  (NUM_FLOORS),
        .FLOOR_W     (FLOOR_W),
        .HOME_FLOOR  (HOME_FLOOR),
        .HOME_TIMEOUT(HOME_TIMEOUT)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .interior_panel(ip),
        .interior_valid(iv),
        .exterior_panel(ep),
        .exterior_valid(ev),
        .current_floor (cf),
        .arrived       (arr),
        .target_floor  (target_floor),
        .target_valid  (target_valid),
        .direction     (direction),
        .pending       (pending)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [NUM_FLOORS-1:0] pend;
        logic [FLOOR_W-1:0]    tgt;
        logic                  vld;
        logic [1:0]            dir;
    } exp_t;

    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    // Reference model state: 0 idle, 1 up, 2 down.
    logic [NUM_FLOORS-1:0] m_pend  = '0;
    logic [FLOOR_W-1:0]    m_tgt   = '0;
    int                    m_state = 0;
    int                    m_cnt   = 0;

    // One clock: predict the post-edge outputs, queue them, clock, then pop and
    // compare against the DUT. Strobes are single-cycle, so they drop after.
    task automatic tick();
        exp_t e;
        exp_t got;
        logic [NUM_FLOORS-1:0] np;
        int up_f, dn_f, ns, c;
        logic hs;
        c    = int'(cf);
        up_f = -1;
        dn_f = -1;
        for (int f = c; f < NUM_FLOORS; f++)
            if (m_pend[f] && up_f < 0) up_f = f;
        for (int f = c; f >= 0; f--)
            if (f < NUM_FLOORS && dn_f < 0) if (m_pend[f]) dn_f = f;
        if (RST) begin
            e.pend = '0; e.tgt = '0; e.vld = 1'b0; e.dir = 2'b00;
            m_state = 0; m_cnt = 0;
        end else begin
            e.vld = (m_pend != '0);
            e.tgt = m_tgt;
            if (m_state == 2) begin
                if (dn_f >= 0)      begin ns = 2; e.tgt = FLOOR_W'(dn_f); end
                else if (up_f >= 0) begin ns = 1; e.tgt = FLOOR_W'(up_f); end
                else                ns = 0;
            end else begin
                if (up_f >= 0)      begin ns = 1; e.tgt = FLOOR_W'(up_f); end
                else if (dn_f >= 0) begin ns = 2; e.tgt = FLOOR_W'(dn_f); end
                else                ns = 0;
            end
            e.dir = (ns == 1) ? 2'b01 : (ns == 2) ? 2'b10 : 2'b00;
            hs = 1'b0;
`ifdef HOME_RETURN_EN
            if (m_state == 0 && m_pend == '0 && c != HOME_FLOOR && !(iv || ev || arr)) begin
                if (m_cnt == HOME_TIMEOUT - 1) begin hs = 1'b1; m_cnt = 0; end
                else m_cnt = m_cnt + 1;
            end else m_cnt = 0;
`endif
            np = m_pend;
            if (iv && int'(ip) < NUM_FLOORS) np[int'(ip)] = 1'b1;
            if (ev && int'(ep) < NUM_FLOORS) np[int'(ep)] = 1'b1;
            if (hs) np[HOME_FLOOR] = 1'b1;
            if (arr && c < NUM_FLOORS) np[c] = 1'b0;
            e.pend  = np;
            m_state = ns;
        end
        m_pend = e.pend;
        m_tgt  = e.tgt;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        got = exp_q.pop_front();
        checks++;
        if (pending !== got.pend || target_floor !== got.tgt ||
            target_valid !== got.vld || direction !== got.dir) begin
            errors++;
            $display("FAIL scoreboard t=%0t: got pend=%h tgt=%0d vld=%b dir=%b, want pend=%h tgt=%0d vld=%b dir=%b",
                     $time, pending, target_floor, target_valid, direction,
                     got.pend, got.tgt, got.vld, got.dir);
        end
        iv = 1'b0; ev = 1'b0; arr = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ip = FLOOR_W'($urandom_range(0, 15)); iv = 1'b1;
            ep = FLOOR_W'($urandom_range(0, 15)); ev = 1'b1;
            tick();
        end
        RST = 1'b0;
        checks++;
        if (pending !== 8'h00 || target_valid !== 1'b0 || direction !== 2'b00 || target_floor !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: pend=%h vld=%b dir=%b tgt=%0d, want 00/0/00/0",
                     pending, target_valid, direction, target_floor);
        end
    endtask

    task automatic test_basic_request();
        cf = 4'd0;
        ip = 4'd5; iv = 1'b1;
        tick();
        checks++;
        if (pending !== 8'h20) begin
            errors++; $display("FAIL capture_5: pend=%h want 20", pending);
        end
        tick();
        checks++;
        if (target_floor !== 4'd5 || target_valid !== 1'b1 || direction !== 2'b01) begin
            errors++;
            $display("FAIL first_target: tgt=%0d vld=%b dir=%b want 5/1/01", target_floor, target_valid, direction);
        end
    endtask

    task automatic test_retarget();
        cf = 4'd2;
        tick();
        ep = 4'd3; ev = 1'b1;
        tick();
        tick();
        checks++;
        if (target_floor !== 4'd3 || direction !== 2'b01) begin
            errors++; $display("FAIL retarget_3: tgt=%0d dir=%b want 3/01", target_floor, direction);
        end
        cf = 4'd3; arr = 1'b1;
        tick();
        checks++;
        if (pending !== 8'h20) begin
            errors++; $display("FAIL arrive_3: pend=%h want 20", pending);
        end
        tick();
        checks++;
        if (target_floor !== 4'd5 || direction !== 2'b01) begin
            errors++; $display("FAIL resume_5: tgt=%0d dir=%b want 5/01", target_floor, direction);
        end
    endtask

    task automatic test_reverse();
        // Floor 1 is requested while heading up; arrival at 5 leaves only bit 1.
        cf = 4'd5; arr = 1'b1; ip = 4'd1; iv = 1'b1;
        tick();
        checks++;
        if (pending !== 8'h02) begin
            errors++; $display("FAIL only_1: pend=%h want 02", pending);
        end
        cf = 4'd4;
        tick();
        checks++;
        if (direction !== 2'b10 || target_floor !== 4'd1) begin
            errors++; $display("FAIL reverse: dir=%b tgt=%0d want 10/1", direction, target_floor);
        end
        cf = 4'd1; arr = 1'b1;
        tick();
        checks++;
        if (pending !== 8'h00) begin
            errors++; $display("FAIL arrive_1: pend=%h want 00", pending);
        end
        tick();
        checks++;
        if (target_valid !== 1'b0 || direction !== 2'b00 || target_floor !== 4'd1) begin
            errors++;
            $display("FAIL go_idle: vld=%b dir=%b tgt=%0d want 0/00/1", target_valid, direction, target_floor);
        end
    endtask

    task automatic test_same_cycle();
        cf = 4'd0;
        ip = 4'd6; iv = 1'b1; ep = 4'd6; ev = 1'b1;
        tick();
        checks++;
        if (pending !== 8'h40) begin
            errors++; $display("FAIL same_floor: pend=%h want 40", pending);
        end
        ip = 4'd7; iv = 1'b1; ep = 4'd2; ev = 1'b1;
        tick();
        checks++;
        if (pending !== 8'hC4) begin
            errors++; $display("FAIL two_floors: pend=%h want c4", pending);
        end
        cf = 4'd4; ep = 4'd4; ev = 1'b1; arr = 1'b1;
        tick();
        checks++;
        if (pending !== 8'hC4) begin
            errors++; $display("FAIL served_on_arrival: pend=%h want c4", pending);
        end
        ip = 4'd9; iv = 1'b1; ep = 4'd12; ev = 1'b1;
        tick();
        checks++;
        if (pending !== 8'hC4) begin
            errors++; $display("FAIL out_of_range: pend=%h want c4", pending);
        end
        ip = 4'd4; iv = 1'b1;
        tick();
        checks++;
        if (pending !== 8'hD4) begin
            errors++; $display("FAIL door_reopen: pend=%h want d4", pending);
        end
        ip = 4'd6; iv = 1'b1;
        tick();
        checks++;
        if (pending !== 8'hD4) begin
            errors++; $display("FAIL repeat_press: pend=%h want d4", pending);
        end
    endtask

    task automatic test_home();
        int bad;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        cf = 4'd3;
`ifdef HOME_RETURN_EN
        for (int k = 0; k < HOME_TIMEOUT - 1; k++) tick();
        checks++;
        if (pending !== 8'h00) begin
            errors++; $display("FAIL home_early: pend=%h want 00", pending);
        end
        tick();
        checks++;
        if (pending !== 8'h01) begin
            errors++; $display("FAIL home_set: pend=%h want 01", pending);
        end
        tick();
        checks++;
        if (direction !== 2'b10 || target_floor !== 4'd0) begin
            errors++; $display("FAIL home_sweep: dir=%b tgt=%0d want 10/0", direction, target_floor);
        end
`else
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (direction !== 2'b00 || pending !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL parked: %0d cycles left idle/empty, want 0", bad);
        end
`endif
    endtask

    task automatic test_reset_mid_sweep();
        cf = 4'd0;
        ip = 4'd7; iv = 1'b1; ep = 4'd2; ev = 1'b1;
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (pending !== 8'h00 || target_valid !== 1'b0 || direction !== 2'b00 || target_floor !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset: pend=%h vld=%b dir=%b tgt=%0d want 00/0/00/0",
                     pending, target_valid, direction, target_floor);
        end
        tick();
        tick();
    endtask

    initial begin
        RST = 1'b0;
        ip = '0; ep = '0; cf = '0;
        iv = 1'b0; ev = 1'b0; arr = 1'b0;
        test_reset();
        test_basic_request();
        test_retarget();
        test_reverse();
        test_same_cycle();
        test_home();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
